// File: rtl/axi_join_cut_if.sv
// AXI4 bus interface shared by both sides of axi_join_cut.
// Modport "in" is the subordinate view and modport "out" is the manager view.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport in (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid, output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );

    modport out (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input  b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid, input ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );
endinterface

// File: rtl/axi_join_cut.sv
// axi_join_cut: AXI4 connector between a slave-side and a master-side AXI_BUS.
// Each channel is either a two-entry spill register (Cut*=1) or a plain wire (Cut*=0).
// Request IDs are zero-extended from SlvIdWidth to MstIdWidth; response IDs are truncated back.
// Optional feature macro: AXI_JOIN_CUT_CNT_EN adds aw_cnt_o / ar_cnt_o handshake counters.

// Two-entry spill register; slot A drives the output, slot B absorbs one beat of backpressure.
module axi_join_cut_spill #(
    parameter int unsigned Width = 1,
    parameter bit          Cut   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);
    if (Cut) begin : g_cut
        typedef enum logic [1:0] {
            ST_EMPTY = 2'd0,
            ST_ONE   = 2'd1,
            ST_TWO   = 2'd2
        } state_e;

        state_e           state_q, state_d;
        logic [Width-1:0] a_q, a_d;
        logic [Width-1:0] b_q, b_d;
        logic             push_s;
        logic             pop_s;

        // Handshakes only depend on registered state, so no input-to-output path exists.
        assign ready_o = (state_q != ST_TWO);
        assign valid_o = (state_q != ST_EMPTY);
        assign data_o  = a_q;
        assign push_s  = valid_i && ready_o;
        assign pop_s   = valid_o && ready_i;

        // Next-state and slot update for the EMPTY/ONE/TWO occupancy machine.
        always_comb begin
            state_d = state_q;
            a_d     = a_q;
            b_d     = b_q;
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        a_d     = data_i;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        a_d     = data_i;
                        state_d = ST_ONE;
                    end else if (push_s) begin
                        b_d     = data_i;
                        state_d = ST_TWO;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        a_d     = b_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        // State and slot registers; reset clears both slots and discards buffered beats.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_EMPTY;
                a_q     <= '0;
                b_q     <= '0;
            end else begin
                state_q <= state_d;
                a_q     <= a_d;
                b_q     <= b_d;
            end
        end
    end else begin : g_wire
        logic unused_clk_rst_s;

        assign unused_clk_rst_s = clk_i ^ rst_ni;
        assign ready_o          = ready_i;
        assign valid_o          = valid_i;
        assign data_o           = data_i;
    end
endmodule

// Protocol checks on the response IDs coming back from the master side.
module axi_join_cut_chk #(
    parameter int unsigned SlvIdWidth = 4,
    parameter int unsigned MstIdWidth = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    input logic                  b_valid_i,
    input logic [MstIdWidth-1:0] b_id_i,
    input logic                  r_valid_i,
    input logic [MstIdWidth-1:0] r_id_i
);
    // IDs returned downstream must fit into the narrower upstream ID space.
    a_b_id_upper_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_valid_i |-> ((b_id_i >> SlvIdWidth) == '0))
        else $error("axi_join_cut: mst.b_id has non-zero upper bits");

    a_r_id_upper_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_valid_i |-> ((r_id_i >> SlvIdWidth) == '0))
        else $error("axi_join_cut: mst.r_id has non-zero upper bits");
endmodule

module axi_join_cut #(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned SlvIdWidth = 4,
    parameter int unsigned MstIdWidth = 4,
    parameter int unsigned UserWidth  = 1,
    parameter bit          CutAw      = 1'b1,
    parameter bit          CutW       = 1'b1,
    parameter bit          CutB       = 1'b1,
    parameter bit          CutAr      = 1'b1,
    parameter bit          CutR       = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    AXI_BUS.in          slv,
    AXI_BUS.out         mst
`ifdef AXI_JOIN_CUT_CNT_EN
    ,
    output logic [31:0] aw_cnt_o,
    output logic [31:0] ar_cnt_o
`endif
);
    localparam int unsigned AxW = MstIdWidth + AddrWidth + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + UserWidth;
    localparam int unsigned WW  = DataWidth + DataWidth / 8 + 1 + UserWidth;
    localparam int unsigned BW  = SlvIdWidth + 2 + UserWidth;
    localparam int unsigned RW  = SlvIdWidth + DataWidth + 2 + 1 + UserWidth;

    // Configurations that cannot work are rejected while elaborating.
    if (MstIdWidth < SlvIdWidth) begin : g_bad_id_width
        $fatal(1, "axi_join_cut: MstIdWidth must be >= SlvIdWidth");
    end
    if ((DataWidth < 8) || ((DataWidth & (DataWidth - 1)) != 0)) begin : g_bad_data_width
        $fatal(1, "axi_join_cut: DataWidth must be a power of two and >= 8");
    end
    if ((slv.AXI_ADDR_WIDTH != AddrWidth) || (mst.AXI_ADDR_WIDTH != AddrWidth) ||
        (slv.AXI_DATA_WIDTH != DataWidth) || (mst.AXI_DATA_WIDTH != DataWidth) ||
        (slv.AXI_ID_WIDTH != SlvIdWidth) || (mst.AXI_ID_WIDTH != MstIdWidth) ||
        (slv.AXI_USER_WIDTH != UserWidth) || (mst.AXI_USER_WIDTH != UserWidth)) begin : g_bad_if
        $fatal(1, "axi_join_cut: interface widths do not match module parameters");
    end

    logic [AxW-1:0] aw_in_s, aw_out_s, ar_in_s, ar_out_s;
    logic [WW-1:0]  w_in_s, w_out_s;
    logic [BW-1:0]  b_in_s, b_out_s;
    logic [RW-1:0]  r_in_s, r_out_s;

    // Request IDs widen on the way down, response IDs narrow on the way up.
    assign aw_in_s = {MstIdWidth'(slv.aw_id), slv.aw_addr, slv.aw_len, slv.aw_size, slv.aw_burst,
                      slv.aw_lock, slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_region, slv.aw_user};
    assign {mst.aw_id, mst.aw_addr, mst.aw_len, mst.aw_size, mst.aw_burst, mst.aw_lock,
            mst.aw_cache, mst.aw_prot, mst.aw_qos, mst.aw_region, mst.aw_user} = aw_out_s;

    assign w_in_s = {slv.w_data, slv.w_strb, slv.w_last, slv.w_user};
    assign {mst.w_data, mst.w_strb, mst.w_last, mst.w_user} = w_out_s;

    assign b_in_s = {SlvIdWidth'(mst.b_id), mst.b_resp, mst.b_user};
    assign {slv.b_id, slv.b_resp, slv.b_user} = b_out_s;

    assign ar_in_s = {MstIdWidth'(slv.ar_id), slv.ar_addr, slv.ar_len, slv.ar_size, slv.ar_burst,
                      slv.ar_lock, slv.ar_cache, slv.ar_prot, slv.ar_qos, slv.ar_region, slv.ar_user};
    assign {mst.ar_id, mst.ar_addr, mst.ar_len, mst.ar_size, mst.ar_burst, mst.ar_lock,
            mst.ar_cache, mst.ar_prot, mst.ar_qos, mst.ar_region, mst.ar_user} = ar_out_s;

    assign r_in_s = {SlvIdWidth'(mst.r_id), mst.r_data, mst.r_resp, mst.r_last, mst.r_user};
    assign {slv.r_id, slv.r_data, slv.r_resp, slv.r_last, slv.r_user} = r_out_s;

    axi_join_cut_spill #(.Width(AxW), .Cut(CutAw)) u_aw (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(slv.aw_valid), .ready_o(slv.aw_ready), .data_i(aw_in_s),
        .valid_o(mst.aw_valid), .ready_i(mst.aw_ready), .data_o(aw_out_s)
    );

    axi_join_cut_spill #(.Width(WW), .Cut(CutW)) u_w (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(slv.w_valid), .ready_o(slv.w_ready), .data_i(w_in_s),
        .valid_o(mst.w_valid), .ready_i(mst.w_ready), .data_o(w_out_s)
    );

    axi_join_cut_spill #(.Width(BW), .Cut(CutB)) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(mst.b_valid), .ready_o(mst.b_ready), .data_i(b_in_s),
        .valid_o(slv.b_valid), .ready_i(slv.b_ready), .data_o(b_out_s)
    );

    axi_join_cut_spill #(.Width(AxW), .Cut(CutAr)) u_ar (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(slv.ar_valid), .ready_o(slv.ar_ready), .data_i(ar_in_s),
        .valid_o(mst.ar_valid), .ready_i(mst.ar_ready), .data_o(ar_out_s)
    );

    axi_join_cut_spill #(.Width(RW), .Cut(CutR)) u_r (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .valid_i(mst.r_valid), .ready_o(mst.r_ready), .data_i(r_in_s),
        .valid_o(slv.r_valid), .ready_i(slv.r_ready), .data_o(r_out_s)
    );

    axi_join_cut_chk #(.SlvIdWidth(SlvIdWidth), .MstIdWidth(MstIdWidth)) u_chk (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .b_valid_i(mst.b_valid), .b_id_i(mst.b_id),
        .r_valid_i(mst.r_valid), .r_id_i(mst.r_id)
    );

`ifdef AXI_JOIN_CUT_CNT_EN
    logic [31:0] aw_cnt_q, aw_cnt_d;
    logic [31:0] ar_cnt_q, ar_cnt_d;

    // Count accepted upstream address handshakes; the adders wrap naturally.
    always_comb begin
        aw_cnt_d = aw_cnt_q;
        ar_cnt_d = ar_cnt_q;
        if (slv.aw_valid && slv.aw_ready) begin
            aw_cnt_d = aw_cnt_q + 32'd1;
        end else begin
            aw_cnt_d = aw_cnt_q;
        end
        if (slv.ar_valid && slv.ar_ready) begin
            ar_cnt_d = ar_cnt_q + 32'd1;
        end else begin
            ar_cnt_d = ar_cnt_q;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_cnt_q <= 32'd0;
            ar_cnt_q <= 32'd0;
        end else begin
            aw_cnt_q <= aw_cnt_d;
            ar_cnt_q <= ar_cnt_d;
        end
    end

    assign aw_cnt_o = aw_cnt_q;
    assign ar_cnt_o = ar_cnt_q;
`endif
endmodule

// File: tb/tb_axi_join_cut.sv
// Bench for axi_join_cut: dut_a has every channel cut, dut_b is all wires.
// Both widen 4-bit upstream IDs to 6-bit downstream IDs.
module tb_axi_join_cut;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) slv_a ();
    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(1)) mst_a ();
    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) slv_b ();
    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(1)) mst_b ();

`ifdef AXI_JOIN_CUT_CNT_EN
    logic [31:0] aw_cnt_a, ar_cnt_a, aw_cnt_b, ar_cnt_b;
`endif

    axi_join_cut #(
        .AddrWidth(64), .DataWidth(64), .SlvIdWidth(4), .MstIdWidth(6), .UserWidth(1),
        .CutAw(1'b1), .CutW(1'b1), .CutB(1'b1), .CutAr(1'b1), .CutR(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .slv(slv_a), .mst(mst_a)
`ifdef AXI_JOIN_CUT_CNT_EN
        , .aw_cnt_o(aw_cnt_a), .ar_cnt_o(ar_cnt_a)
`endif
    );

    axi_join_cut #(
        .AddrWidth(64), .DataWidth(64), .SlvIdWidth(4), .MstIdWidth(6), .UserWidth(1),
        .CutAw(1'b0), .CutW(1'b0), .CutB(1'b0), .CutAr(1'b0), .CutR(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .slv(slv_b), .mst(mst_b)
`ifdef AXI_JOIN_CUT_CNT_EN
        , .aw_cnt_o(aw_cnt_b), .ar_cnt_o(ar_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected summary before 200000");
        $fatal(1, "timeout");
    end

    task automatic bus_idle();
        slv_a.aw_valid = 1'b0; slv_a.aw_id = 4'h0; slv_a.aw_addr = 64'h0; slv_a.aw_len = 8'h0;
        slv_a.aw_size = 3'h3; slv_a.aw_burst = 2'h1; slv_a.aw_lock = 1'b0; slv_a.aw_cache = 4'h0;
        slv_a.aw_prot = 3'h0; slv_a.aw_qos = 4'h0; slv_a.aw_region = 4'h0; slv_a.aw_user = 1'b0;
        slv_a.w_valid = 1'b0; slv_a.w_data = 64'h0; slv_a.w_strb = 8'h0; slv_a.w_last = 1'b0;
        slv_a.w_user = 1'b0; slv_a.b_ready = 1'b0;
        slv_a.ar_valid = 1'b0; slv_a.ar_id = 4'h0; slv_a.ar_addr = 64'h0; slv_a.ar_len = 8'h0;
        slv_a.ar_size = 3'h3; slv_a.ar_burst = 2'h1; slv_a.ar_lock = 1'b0; slv_a.ar_cache = 4'h0;
        slv_a.ar_prot = 3'h0; slv_a.ar_qos = 4'h0; slv_a.ar_region = 4'h0; slv_a.ar_user = 1'b0;
        slv_a.r_ready = 1'b0;
        mst_a.aw_ready = 1'b0; mst_a.w_ready = 1'b0; mst_a.ar_ready = 1'b0;
        mst_a.b_valid = 1'b0; mst_a.b_id = 6'h0; mst_a.b_resp = 2'h0; mst_a.b_user = 1'b0;
        mst_a.r_valid = 1'b0; mst_a.r_id = 6'h0; mst_a.r_data = 64'h0; mst_a.r_resp = 2'h0;
        mst_a.r_last = 1'b0; mst_a.r_user = 1'b0;
        slv_b.aw_valid = 1'b0; slv_b.aw_id = 4'h0; slv_b.aw_addr = 64'h0; slv_b.aw_len = 8'h0;
        slv_b.aw_size = 3'h3; slv_b.aw_burst = 2'h1; slv_b.aw_lock = 1'b0; slv_b.aw_cache = 4'h0;
        slv_b.aw_prot = 3'h0; slv_b.aw_qos = 4'h0; slv_b.aw_region = 4'h0; slv_b.aw_user = 1'b0;
        slv_b.w_valid = 1'b0; slv_b.w_data = 64'h0; slv_b.w_strb = 8'h0; slv_b.w_last = 1'b0;
        slv_b.w_user = 1'b0; slv_b.b_ready = 1'b0;
        slv_b.ar_valid = 1'b0; slv_b.ar_id = 4'h0; slv_b.ar_addr = 64'h0; slv_b.ar_len = 8'h0;
        slv_b.ar_size = 3'h3; slv_b.ar_burst = 2'h1; slv_b.ar_lock = 1'b0; slv_b.ar_cache = 4'h0;
        slv_b.ar_prot = 3'h0; slv_b.ar_qos = 4'h0; slv_b.ar_region = 4'h0; slv_b.ar_user = 1'b0;
        slv_b.r_ready = 1'b0;
        mst_b.aw_ready = 1'b0; mst_b.w_ready = 1'b0; mst_b.ar_ready = 1'b0;
        mst_b.b_valid = 1'b0; mst_b.b_id = 6'h0; mst_b.b_resp = 2'h0; mst_b.b_user = 1'b0;
        mst_b.r_valid = 1'b0; mst_b.r_id = 6'h0; mst_b.r_data = 64'h0; mst_b.r_resp = 2'h0;
        mst_b.r_last = 1'b0; mst_b.r_user = 1'b0;
    endtask

    // Reset state of the cut instance, checked during and after reset.
    task automatic test_reset();
        logic [4:0] vld;
        logic [4:0] rdy;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vld = {mst_a.aw_valid, mst_a.w_valid, mst_a.ar_valid, slv_a.b_valid, slv_a.r_valid};
        rdy = {slv_a.aw_ready, slv_a.w_ready, slv_a.ar_ready, mst_a.b_ready, mst_a.r_ready};
        n_cmp++; if (vld !== 5'b00000) begin n_bad++; $display("FAIL reset_valids: got %b expected %b", vld, 5'b00000); end
        n_cmp++; if (rdy !== 5'b11111) begin n_bad++; $display("FAIL reset_readies: got %b expected %b", rdy, 5'b11111); end
        n_cmp++; if (mst_a.aw_addr !== 64'h0) begin n_bad++; $display("FAIL reset_aw_addr: got %h expected %h", mst_a.aw_addr, 64'h0); end
        n_cmp++; if (mst_a.w_data !== 64'h0) begin n_bad++; $display("FAIL reset_w_data: got %h expected %h", mst_a.w_data, 64'h0); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (mst_a.aw_valid !== 1'b0 || slv_a.aw_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_reset_aw: got valid %b ready %b expected 0 1", mst_a.aw_valid, slv_a.aw_ready);
        end
    endtask

    // 16 back-to-back AW beats through the cut: 1-cycle latency, no stall, order kept.
    task automatic test_aw_stream();
        logic [69:0] exp_q[$];
        logic [69:0] exp;
        int sent = 0;
        int got = 0;
        bit prev_acc = 1'b0;
        mst_a.aw_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            slv_a.aw_valid = (sent < 16);
            slv_a.aw_addr  = 64'h1000 + 64'(sent) * 64'd8;
            slv_a.aw_id    = 4'(sent);
            @(negedge clk);
            n_cmp++; if (mst_a.aw_valid !== prev_acc) begin
                n_bad++; $display("FAIL aw_latency: cycle %0d got valid %b expected %b", c, mst_a.aw_valid, prev_acc);
            end
            if (sent < 16) begin
                n_cmp++; if (slv_a.aw_ready !== 1'b1) begin
                    n_bad++; $display("FAIL aw_ready_held: cycle %0d got %b expected 1", c, slv_a.aw_ready);
                end
            end
            if (mst_a.aw_valid === 1'b1 && mst_a.aw_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL aw_extra_beat: got addr %h expected no beat", mst_a.aw_addr);
                end else begin
                    exp = exp_q.pop_front();
                    if ({mst_a.aw_id, mst_a.aw_addr} !== exp) begin
                        n_bad++; $display("FAIL aw_order: got %h expected %h", {mst_a.aw_id, mst_a.aw_addr}, exp);
                    end
                end
                got++;
            end
            prev_acc = (slv_a.aw_valid === 1'b1 && slv_a.aw_ready === 1'b1);
            if (prev_acc) begin
                exp_q.push_back({6'(sent), 64'h1000 + 64'(sent) * 64'd8});
                sent++;
            end
            @(posedge clk); #1;
        end
        slv_a.aw_valid = 1'b0;
        n_cmp++; if (got != 16) begin n_bad++; $display("FAIL aw_count: got %0d expected 16", got); end
    endtask

    // Three W beats against a stalled master: upstream ready drops once full, data held stable.
    task automatic test_w_stall();
        logic [63:0] exp_q[$];
        logic [63:0] exp;
        int sent = 0;
        int got = 0;
        mst_a.w_ready = 1'b0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            if (c == 6) mst_a.w_ready = 1'b1;
            slv_a.w_valid = (sent < 3);
            slv_a.w_data  = 64'hA5A5_0000_0000_0000 | 64'(sent + 1);
            slv_a.w_strb  = 8'hFF;
            slv_a.w_last  = 1'b1;
            @(negedge clk);
            if (c < 2) begin
                n_cmp++; if (slv_a.w_ready !== 1'b1) begin n_bad++; $display("FAIL w_ready_early: cycle %0d got %b expected 1", c, slv_a.w_ready); end
            end
            if (c == 2) begin
                n_cmp++; if (slv_a.w_ready !== 1'b0) begin n_bad++; $display("FAIL w_ready_full: got %b expected 0", slv_a.w_ready); end
            end
            if (c >= 2 && c < 6) begin
                n_cmp++;
                exp = 64'hA5A5_0000_0000_0001;
                if (mst_a.w_valid !== 1'b1 || mst_a.w_data !== exp) begin
                    n_bad++; $display("FAIL w_stable: cycle %0d got %b/%h expected 1/%h", c, mst_a.w_valid, mst_a.w_data, exp);
                end
            end
            if (mst_a.w_valid === 1'b1 && mst_a.w_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL w_extra_beat: got %h expected no beat", mst_a.w_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (mst_a.w_data !== exp) begin n_bad++; $display("FAIL w_order: got %h expected %h", mst_a.w_data, exp); end
                end
                got++;
            end
            if (slv_a.w_valid === 1'b1 && slv_a.w_ready === 1'b1) begin
                exp_q.push_back(64'hA5A5_0000_0000_0000 | 64'(sent + 1));
                sent++;
            end
            @(posedge clk); #1;
        end
        slv_a.w_valid = 1'b0;
        n_cmp++; if (got != 3) begin n_bad++; $display("FAIL w_count: got %0d expected 3", got); end
    endtask

    // AR ID widening and R ID narrowing through the cut instance.
    task automatic test_id_widen();
        logic [69:0] ar_q[$];
        logic [67:0] r_q[$];
        logic [69:0] ar_exp;
        logic [67:0] r_exp;
        int ar_got = 0;
        int r_got = 0;
        mst_a.ar_ready = 1'b1;
        slv_a.r_ready  = 1'b1;
        slv_a.ar_valid = 1'b1; slv_a.ar_id = 4'hA; slv_a.ar_addr = 64'h0000_0000_0000_2000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mst_a.ar_valid === 1'b1 && mst_a.ar_ready === 1'b1) begin
                n_cmp++;
                if (ar_q.size() == 0) begin
                    n_bad++; $display("FAIL ar_extra_beat: got %h expected no beat", mst_a.ar_addr);
                end else begin
                    ar_exp = ar_q.pop_front();
                    if ({mst_a.ar_id, mst_a.ar_addr} !== ar_exp) begin
                        n_bad++; $display("FAIL ar_id_widen: got %h expected %h", {mst_a.ar_id, mst_a.ar_addr}, ar_exp);
                    end
                end
                ar_got++;
            end
            if (slv_a.ar_valid === 1'b1 && slv_a.ar_ready === 1'b1) ar_q.push_back({6'h0A, 64'h0000_0000_0000_2000});
            @(posedge clk); #1;
            slv_a.ar_valid = 1'b0;
        end
        n_cmp++; if (ar_got != 1) begin n_bad++; $display("FAIL ar_count: got %0d expected 1", ar_got); end
        mst_a.r_valid = 1'b1; mst_a.r_id = 6'h05; mst_a.r_data = 64'hCAFE_F00D_1234_5678; mst_a.r_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (slv_a.r_valid === 1'b1 && slv_a.r_ready === 1'b1) begin
                n_cmp++;
                if (r_q.size() == 0) begin
                    n_bad++; $display("FAIL r_extra_beat: got %h expected no beat", slv_a.r_data);
                end else begin
                    r_exp = r_q.pop_front();
                    if ({slv_a.r_id, slv_a.r_data} !== r_exp) begin
                        n_bad++; $display("FAIL r_id_narrow: got %h expected %h", {slv_a.r_id, slv_a.r_data}, r_exp);
                    end
                end
                r_got++;
            end
            if (mst_a.r_valid === 1'b1 && mst_a.r_ready === 1'b1) r_q.push_back({4'h5, 64'hCAFE_F00D_1234_5678});
            @(posedge clk); #1;
            mst_a.r_valid = 1'b0;
        end
        n_cmp++; if (r_got != 1) begin n_bad++; $display("FAIL r_count: got %0d expected 1", r_got); end
    endtask

    // All-wire instance: outputs follow random inputs in the same time step.
    task automatic test_passthrough();
        logic [63:0] addr, wdat, rdat;
        logic [3:0]  id;
        logic [3:0]  rid;
        logic [5:0]  vl;
        logic [4:0]  rd;
        for (int i = 0; i < 6; i++) begin
            addr = {$urandom, $urandom}; wdat = {$urandom, $urandom}; rdat = {$urandom, $urandom};
            id = 4'($urandom); rid = 4'($urandom); vl = 6'($urandom); rd = 5'($urandom);
            slv_b.aw_valid = vl[0]; slv_b.aw_addr = addr; slv_b.aw_id = id;
            slv_b.w_valid = vl[1]; slv_b.w_data = wdat;
            slv_b.ar_valid = vl[2]; slv_b.ar_addr = ~addr; slv_b.ar_id = ~id;
            mst_b.b_valid = vl[3]; mst_b.b_id = {2'b00, rid}; mst_b.b_resp = vl[5:4];
            mst_b.r_valid = vl[4]; mst_b.r_id = {2'b00, ~rid}; mst_b.r_data = rdat;
            mst_b.aw_ready = rd[0]; mst_b.w_ready = rd[1]; mst_b.ar_ready = rd[2];
            slv_b.b_ready = rd[3]; slv_b.r_ready = rd[4];
            #1;
            n_cmp++; if ({mst_b.aw_valid, mst_b.aw_id, mst_b.aw_addr} !== {vl[0], 2'b00, id, addr}) begin
                n_bad++; $display("FAIL pt_aw: got %h expected %h", {mst_b.aw_valid, mst_b.aw_id, mst_b.aw_addr}, {vl[0], 2'b00, id, addr});
            end
            n_cmp++; if ({mst_b.w_valid, mst_b.w_data} !== {vl[1], wdat}) begin
                n_bad++; $display("FAIL pt_w: got %h expected %h", {mst_b.w_valid, mst_b.w_data}, {vl[1], wdat});
            end
            n_cmp++; if ({mst_b.ar_valid, mst_b.ar_id, mst_b.ar_addr} !== {vl[2], 2'b00, ~id, ~addr}) begin
                n_bad++; $display("FAIL pt_ar: got %h expected %h", {mst_b.ar_valid, mst_b.ar_id, mst_b.ar_addr}, {vl[2], 2'b00, ~id, ~addr});
            end
            n_cmp++; if ({slv_b.b_valid, slv_b.b_id, slv_b.b_resp} !== {vl[3], rid, vl[5:4]}) begin
                n_bad++; $display("FAIL pt_b: got %h expected %h", {slv_b.b_valid, slv_b.b_id, slv_b.b_resp}, {vl[3], rid, vl[5:4]});
            end
            n_cmp++; if ({slv_b.r_valid, slv_b.r_id, slv_b.r_data} !== {vl[4], ~rid, rdat}) begin
                n_bad++; $display("FAIL pt_r: got %h expected %h", {slv_b.r_valid, slv_b.r_id, slv_b.r_data}, {vl[4], ~rid, rdat});
            end
            n_cmp++; if ({slv_b.aw_ready, slv_b.w_ready, slv_b.ar_ready, mst_b.b_ready, mst_b.r_ready} !== {rd[0], rd[1], rd[2], rd[3], rd[4]}) begin
                n_bad++; $display("FAIL pt_ready: got %b expected %b",
                    {slv_b.aw_ready, slv_b.w_ready, slv_b.ar_ready, mst_b.b_ready, mst_b.r_ready}, {rd[0], rd[1], rd[2], rd[3], rd[4]});
            end
            @(posedge clk); #1;
        end
        mst_b.b_valid = 1'b0; mst_b.r_valid = 1'b0;
    endtask

    // Reset while the W slice holds two beats: everything clears and the beats never reappear.
    task automatic test_reset_mid();
        logic [4:0] vld;
        logic [4:0] rdy;
        mst_a.w_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            slv_a.w_valid = 1'b1;
            slv_a.w_data  = 64'hDEAD_BEEF_0000_0000 | 64'(c);
            @(posedge clk); #1;
        end
        slv_a.w_valid = 1'b0;
        n_cmp++; if (slv_a.w_ready !== 1'b0) begin n_bad++; $display("FAIL pre_reset_full: got %b expected 0", slv_a.w_ready); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        vld = {mst_a.aw_valid, mst_a.w_valid, mst_a.ar_valid, slv_a.b_valid, slv_a.r_valid};
        rdy = {slv_a.aw_ready, slv_a.w_ready, slv_a.ar_ready, mst_a.b_ready, mst_a.r_ready};
        n_cmp++; if (vld !== 5'b00000) begin n_bad++; $display("FAIL mid_reset_valids: got %b expected %b", vld, 5'b00000); end
        n_cmp++; if (rdy !== 5'b11111) begin n_bad++; $display("FAIL mid_reset_readies: got %b expected %b", rdy, 5'b11111); end
        @(negedge clk);
        rst_n = 1'b1;
        mst_a.w_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (mst_a.w_valid !== 1'b0) begin
                n_bad++; $display("FAIL stale_beat: cycle %0d got valid %b data %h expected 0", c, mst_a.w_valid, mst_a.w_data);
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef AXI_JOIN_CUT_CNT_EN
    // Handshake counters: 5 AW and 3 AR from zero, then wrap from all-ones.
    task automatic test_counters();
        int aw_n = 0;
        int ar_n = 0;
        mst_a.aw_ready = 1'b1; mst_a.ar_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            slv_a.aw_valid = (aw_n < 5);
            slv_a.ar_valid = (ar_n < 3);
            @(negedge clk);
            if (slv_a.aw_valid === 1'b1 && slv_a.aw_ready === 1'b1) aw_n++;
            if (slv_a.ar_valid === 1'b1 && slv_a.ar_ready === 1'b1) ar_n++;
            @(posedge clk); #1;
        end
        slv_a.aw_valid = 1'b0; slv_a.ar_valid = 1'b0;
        n_cmp++; if (aw_cnt_a !== 32'd5) begin n_bad++; $display("FAIL aw_cnt: got %0d expected 5", aw_cnt_a); end
        n_cmp++; if (ar_cnt_a !== 32'd3) begin n_bad++; $display("FAIL ar_cnt: got %0d expected 3", ar_cnt_a); end
        force dut_a.aw_cnt_q = 32'hFFFF_FFFF;
        #1 release dut_a.aw_cnt_q;
        slv_a.aw_valid = 1'b1;
        @(posedge clk); #1;
        slv_a.aw_valid = 1'b0;
        n_cmp++; if (aw_cnt_a !== 32'd0) begin n_bad++; $display("FAIL aw_cnt_wrap: got %h expected %h", aw_cnt_a, 32'd0); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst_n = 1'b1;
        bus_idle();
        test_reset();
        test_aw_stream();
        test_w_stall();
        test_id_widen();
        test_passthrough();
        test_reset_mid();
`ifdef AXI_JOIN_CUT_CNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
